// File: rtl/entity_scan_sequencer.sv
// entity_scan_sequencer
// Owns the shared entity select/read/write bus. Each frame_start scans the player and
// enemies into a shadow bank and commits it to a CPU-visible bank in one cycle. CPU
// direction writes are interleaved on the same bus between entities.
module entity_scan_sequencer #(
    parameter int unsigned N_ENT  = 6,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned IDX_W  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_start,
    output logic [IDX_W-1:0] ent_select,
    output logic             ent_read,
    output logic             ent_write,
    output logic [1:0]       ent_sel_dir,
    input  logic [9:0]       ent_X,
    input  logic [9:0]       ent_Y,
    input  logic             ent_Active,
    input  logic             cpu_wr_req,
    input  logic [IDX_W-1:0] cpu_wr_idx,
    input  logic [1:0]       cpu_wr_dir,
    output logic             cpu_wr_ack,
    input  logic [IDX_W-1:0] cpu_rd_idx,
    output logic [9:0]       cpu_rd_X,
    output logic [9:0]       cpu_rd_Y,
    output logic             cpu_rd_Active,
    output logic             snap_valid,
    output logic             scan_busy,
    output logic             overrun,
    input  logic             ovr_clr
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StSel,
        StWait,
        StCommit
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              scan_pend_q, scan_pend_d;
    logic              scan_busy_q, scan_busy_d;
    logic              wr_block_q, wr_block_d;
    logic              overrun_q, overrun_d;
    logic [IDX_W-1:0]  ent_select_q, ent_select_d;
    logic              ent_read_q, ent_read_d;
    logic              ent_write_q, ent_write_d;
    logic [1:0]        ent_sel_dir_q, ent_sel_dir_d;
    logic              cpu_wr_ack_q, cpu_wr_ack_d;
    logic              snap_valid_q, snap_valid_d;

    logic              capture;
    logic              start_scan;
    logic              wr_take;
    logic              last_ent;
    logic              settle_done;
    logic              wr_idx_ok;

    logic [9:0]        shadow_x_q [N_ENT];
    logic [9:0]        shadow_y_q [N_ENT];
    logic              shadow_a_q [N_ENT];
    logic [9:0]        vis_x_q    [N_ENT];
    logic [9:0]        vis_y_q    [N_ENT];
    logic              vis_a_q    [N_ENT];

    assign wr_take     = cpu_wr_req && !wr_block_q;
    assign last_ent    = (idx_q == IDX_W'(N_ENT - 1));
    assign settle_done = (cnt_q == CntW'(1));
    // Enemy indices only; the player (0) and out-of-range targets are acked silently.
    assign wr_idx_ok   = (cpu_wr_idx != '0) && (32'(cpu_wr_idx) < N_ENT);

    // Next-state, bookkeeping flags and registered bus outputs derived from next state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        capture = 1'b0;

        case (state_q)
            StIdle: begin
                if (wr_take) begin
                    state_d = StWr;
                end else if (scan_pend_q) begin
                    state_d = StSel;
                    idx_d   = '0;
                end
            end
            StSel: begin
                state_d = StWait;
                cnt_d   = CntW'(SETTLE);
            end
            StWait: begin
                if (settle_done) begin
                    capture = 1'b1;
                    if (wr_take) begin
                        state_d = StWr;
                    end else if (last_ent) begin
                        state_d = StCommit;
                    end else begin
                        state_d = StSel;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWr: begin
                // Resume a suspended scan, or start a scan that was pending behind the write.
                if (scan_busy_q) begin
                    if (last_ent) begin
                        state_d = StCommit;
                    end else begin
                        state_d = StSel;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end else if (scan_pend_q) begin
                    state_d = StSel;
                    idx_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        start_scan = (state_d == StSel) && !scan_busy_q;

        scan_pend_d = scan_pend_q && !start_scan;
        overrun_d   = overrun_q && !ovr_clr;
        if (frame_start) begin
            if (scan_pend_q || scan_busy_q) begin
                overrun_d = 1'b1;
            end else begin
                scan_pend_d = 1'b1;
            end
        end

        if (start_scan) begin
            scan_busy_d = 1'b1;
        end else if (state_q == StCommit) begin
            scan_busy_d = 1'b0;
        end else begin
            scan_busy_d = scan_busy_q;
        end

        // A serviced request must be seen low before another one is accepted.
        wr_block_d = cpu_wr_req && (wr_block_q || (state_d == StWr));

        ent_select_d  = '0;
        ent_read_d    = 1'b0;
        ent_write_d   = 1'b0;
        ent_sel_dir_d = '0;
        case (state_d)
            StSel, StWait: begin
                ent_select_d = idx_d;
                ent_read_d   = 1'b1;
            end
            StWr: begin
                ent_select_d  = cpu_wr_idx;
                ent_sel_dir_d = cpu_wr_dir;
                ent_write_d   = wr_idx_ok;
            end
            default: begin
            end
        endcase

        cpu_wr_ack_d = (state_q == StWr);
        snap_valid_d = (state_q == StCommit);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            scan_pend_q   <= 1'b0;
            scan_busy_q   <= 1'b0;
            wr_block_q    <= 1'b0;
            overrun_q     <= 1'b0;
            ent_select_q  <= '0;
            ent_read_q    <= 1'b0;
            ent_write_q   <= 1'b0;
            ent_sel_dir_q <= '0;
            cpu_wr_ack_q  <= 1'b0;
            snap_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            scan_pend_q   <= scan_pend_d;
            scan_busy_q   <= scan_busy_d;
            wr_block_q    <= wr_block_d;
            overrun_q     <= overrun_d;
            ent_select_q  <= ent_select_d;
            ent_read_q    <= ent_read_d;
            ent_write_q   <= ent_write_d;
            ent_sel_dir_q <= ent_sel_dir_d;
            cpu_wr_ack_q  <= cpu_wr_ack_d;
            snap_valid_q  <= snap_valid_d;
        end
    end

    // Shadow capture at the end of each settle window; whole-bank commit in COMMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_ENT; i++) begin
                shadow_x_q[i] <= '0;
                shadow_y_q[i] <= '0;
                shadow_a_q[i] <= 1'b0;
                vis_x_q[i]    <= '0;
                vis_y_q[i]    <= '0;
                vis_a_q[i]    <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < N_ENT; i++) begin
                if (capture && (idx_q == IDX_W'(i))) begin
                    shadow_x_q[i] <= ent_X;
                    shadow_y_q[i] <= ent_Y;
                    shadow_a_q[i] <= ent_Active;
                end
                if (state_q == StCommit) begin
                    vis_x_q[i] <= shadow_x_q[i];
                    vis_y_q[i] <= shadow_y_q[i];
                    vis_a_q[i] <= shadow_a_q[i];
                end
            end
        end
    end

    // CPU snapshot read port; indices past the last entity read as zero.
    always_comb begin
        cpu_rd_X      = '0;
        cpu_rd_Y      = '0;
        cpu_rd_Active = 1'b0;
        for (int unsigned i = 0; i < N_ENT; i++) begin
            if (cpu_rd_idx == IDX_W'(i)) begin
                cpu_rd_X      = vis_x_q[i];
                cpu_rd_Y      = vis_y_q[i];
                cpu_rd_Active = vis_a_q[i];
            end
        end
    end

    assign ent_select  = ent_select_q;
    assign ent_read    = ent_read_q;
    assign ent_write   = ent_write_q;
    assign ent_sel_dir = ent_sel_dir_q;
    assign cpu_wr_ack  = cpu_wr_ack_q;
    assign snap_valid  = snap_valid_q;
    assign scan_busy   = scan_busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_entity_scan_sequencer.sv
// Bench for entity_scan_sequencer: random entity tables, a snapshot model and
// cycle-count expectations computed from the scan timing rules.
module tb_entity_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_start;
    logic [2:0] ent_select;
    logic       ent_read;
    logic       ent_write;
    logic [1:0] ent_sel_dir;
    logic [9:0] ent_X;
    logic [9:0] ent_Y;
    logic       ent_Active;
    logic       cpu_wr_req;
    logic [2:0] cpu_wr_idx;
    logic [1:0] cpu_wr_dir;
    logic       cpu_wr_ack;
    logic [2:0] cpu_rd_idx;
    logic [9:0] cpu_rd_X;
    logic [9:0] cpu_rd_Y;
    logic       cpu_rd_Active;
    logic       snap_valid;
    logic       scan_busy;
    logic       overrun;
    logic       ovr_clr;

    int n_checks = 0;
    int n_fail   = 0;

    // Entity interface contents per index, and the expected visible snapshot.
    logic [9:0] tab_x [8];
    logic [9:0] tab_y [8];
    logic       tab_a [8];
    logic [9:0] vis_x [8];
    logic [9:0] vis_y [8];
    logic       vis_a [8];

    // Results collected by run_scan.
    int         r_snap, r_nwr, r_wrcyc, r_nack, r_badrd, r_miderr, r_busy;
    logic [2:0] r_wrsel;
    logic [1:0] r_wrdir;

    assign ent_X      = tab_x[ent_select];
    assign ent_Y      = tab_y[ent_select];
    assign ent_Active = tab_a[ent_select];

    always #5 clk = ~clk;

    entity_scan_sequencer #(.N_ENT(6), .SETTLE(2), .IDX_W(3)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .ent_select   (ent_select),
        .ent_read     (ent_read),
        .ent_write    (ent_write),
        .ent_sel_dir  (ent_sel_dir),
        .ent_X        (ent_X),
        .ent_Y        (ent_Y),
        .ent_Active   (ent_Active),
        .cpu_wr_req   (cpu_wr_req),
        .cpu_wr_idx   (cpu_wr_idx),
        .cpu_wr_dir   (cpu_wr_dir),
        .cpu_wr_ack   (cpu_wr_ack),
        .cpu_rd_idx   (cpu_rd_idx),
        .cpu_rd_X     (cpu_rd_X),
        .cpu_rd_Y     (cpu_rd_Y),
        .cpu_rd_Active(cpu_rd_Active),
        .snap_valid   (snap_valid),
        .scan_busy    (scan_busy),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 8; i++) begin
            tab_x[i] = 10'($urandom);
            tab_y[i] = 10'($urandom);
            tab_a[i] = 1'($urandom);
        end
    endtask

    // After a completed scan the visible bank holds entities 0..5 and zero beyond.
    task automatic model_commit();
        for (int i = 0; i < 8; i++) begin
            vis_x[i] = (i < 6) ? tab_x[i] : 10'd0;
            vis_y[i] = (i < 6) ? tab_y[i] : 10'd0;
            vis_a[i] = (i < 6) ? tab_a[i] : 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            vis_x[i] = '0;
            vis_y[i] = '0;
            vis_a[i] = 1'b0;
        end
    endtask

    // Pulses frame_start (sampled at edge 0) and watches cycles 1.. until snap_valid.
    // Optional write request raised in cycle wr_r, second frame_start / ovr_clr in a cycle.
    task automatic run_scan(input int wr_r, input logic [2:0] w_idx, input logic [1:0] w_dir,
                            input int fs2, input int clr_c);
        int rd_cnt [8];
        for (int i = 0; i < 8; i++) rd_cnt[i] = 0;
        r_snap = -1; r_nwr = 0; r_wrcyc = -1; r_nack = 0; r_miderr = 0; r_busy = 0;
        r_wrsel = '0; r_wrdir = '0;
        cpu_rd_idx  = 3'($urandom);
        cpu_wr_idx  = w_idx;
        cpu_wr_dir  = w_dir;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int n = 0; n <= 60; n++) begin
            if (n > 0) begin
                tick();
                if (ent_read) rd_cnt[ent_select]++;
                if (scan_busy) r_busy++;
                if (ent_write) begin
                    r_nwr++;
                    r_wrcyc = n;
                    r_wrsel = ent_select;
                    r_wrdir = ent_sel_dir;
                end
                if (cpu_wr_ack) begin
                    r_nack++;
                    cpu_wr_req = 1'b0;
                end
                if (snap_valid) begin
                    r_snap = n;
                    break;
                end
                if (cpu_rd_X !== vis_x[cpu_rd_idx] || cpu_rd_Y !== vis_y[cpu_rd_idx] ||
                    cpu_rd_Active !== vis_a[cpu_rd_idx]) r_miderr++;
            end
            if (n == wr_r) cpu_wr_req = 1'b1;
            frame_start = (n == fs2);
            ovr_clr     = (n == clr_c);
        end
        frame_start = 1'b0;
        ovr_clr     = 1'b0;
        r_badrd = 0;
        for (int i = 0; i < 8; i++) begin
            if (rd_cnt[i] != ((i < 6) ? 3 : 0)) r_badrd++;
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        reset_n = 1'b0;
        model_clear();
        tick();
        tick();
        obs = {ent_select, ent_read, ent_write, ent_sel_dir, cpu_wr_ack, snap_valid, scan_busy,
               overrun};
        n_checks++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0", obs);
        end
        for (int i = 0; i < 8; i++) begin
            cpu_rd_idx = 3'(i);
            #1;
            n_checks++;
            if ({cpu_rd_X, cpu_rd_Y, cpu_rd_Active} !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_read[%0d]: got %h expected 0", i,
                         {cpu_rd_X, cpu_rd_Y, cpu_rd_Active});
            end
        end
        reset_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({ent_read, scan_busy, snap_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 000",
                     {ent_read, scan_busy, snap_valid});
        end
    endtask

    task automatic test_scan_basic();
        for (int i = 0; i < 8; i++) begin
            tab_x[i] = 10'(10 * i);
            tab_y[i] = 10'(20 * i);
            tab_a[i] = 1'(i % 2);
        end
        run_scan(-1, 3'd0, 2'd0, -1, -1);
        n_checks++;
        if (r_snap !== 20) begin
            n_fail++;
            $display("FAIL basic_snap_cycle: got %0d expected 20", r_snap);
        end
        n_checks++;
        if (r_badrd !== 0 || r_nwr !== 0 || r_miderr !== 0) begin
            n_fail++;
            $display("FAIL basic_bus: badrd %0d writes %0d midscan %0d expected 0 0 0",
                     r_badrd, r_nwr, r_miderr);
        end
        n_checks++;
        if (r_busy !== 19) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d expected 19", r_busy);
        end
        model_commit();
        cpu_rd_idx = 3'd3;
        #1;
        n_checks++;
        if (cpu_rd_X !== 10'd30 || cpu_rd_Y !== 10'd60 || cpu_rd_Active !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_read3: got %0d %0d %0d expected 30 60 1",
                     cpu_rd_X, cpu_rd_Y, cpu_rd_Active);
        end
        tick();
        n_checks++;
        if (snap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL snap_pulse_width: got %b expected 0", snap_valid);
        end
    endtask

    task automatic test_random_scans();
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_scan(-1, 3'd0, 2'd0, -1, -1);
            n_checks++;
            if (r_snap !== 20 || r_badrd !== 0 || r_miderr !== 0) begin
                n_fail++;
                $display("FAIL rand_scan%0d: snap %0d badrd %0d midscan %0d expected 20 0 0",
                         k, r_snap, r_badrd, r_miderr);
            end
            model_commit();
            for (int i = 0; i < 8; i++) begin
                cpu_rd_idx = 3'(i);
                #1;
                n_checks++;
                if (cpu_rd_X !== vis_x[i] || cpu_rd_Y !== vis_y[i] ||
                    cpu_rd_Active !== vis_a[i]) begin
                    n_fail++;
                    $display("FAIL rand_read%0d[%0d]: got %0d %0d %0d expected %0d %0d %0d",
                             k, i, cpu_rd_X, cpu_rd_Y, cpu_rd_Active, vis_x[i], vis_y[i],
                             vis_a[i]);
                end
            end
        end
    endtask

    task automatic test_write_idle();
        logic [2:0] idx;
        logic [1:0] dir;
        for (int k = 0; k < 3; k++) begin
            idx = (k == 0) ? 3'd2 : 3'($urandom_range(1, 5));
            dir = (k == 0) ? 2'd3 : 2'($urandom);
            cpu_wr_idx = idx;
            cpu_wr_dir = dir;
            cpu_wr_req = 1'b1;
            tick();
            n_checks++;
            if ({ent_write, ent_read, cpu_wr_ack, ent_select, ent_sel_dir} !==
                {3'b100, idx, dir}) begin
                n_fail++;
                $display("FAIL wr_idle_strobe%0d: got %b expected %b", k,
                         {ent_write, ent_read, cpu_wr_ack, ent_select, ent_sel_dir},
                         {3'b100, idx, dir});
            end
            tick();
            n_checks++;
            if ({ent_write, cpu_wr_ack, ent_select, ent_sel_dir} !== 7'b0100000) begin
                n_fail++;
                $display("FAIL wr_idle_ack%0d: got %b expected 0100000", k,
                         {ent_write, cpu_wr_ack, ent_select, ent_sel_dir});
            end
            tick();
            tick();
            n_checks++;
            if ({ent_write, cpu_wr_ack} !== 2'b00) begin
                n_fail++;
                $display("FAIL wr_no_double%0d: got %b expected 00", k, {ent_write, cpu_wr_ack});
            end
            cpu_wr_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_write_during_scan();
        int         r;
        int         exp_wr;
        logic [2:0] idx;
        logic [1:0] dir;
        for (int k = 0; k < 4; k++) begin
            fill_random();
            r   = (k == 0) ? 5 : int'($urandom_range(0, 18));
            idx = (k == 0) ? 3'd4 : 3'($urandom_range(1, 5));
            dir = 2'($urandom);
            // Taken at the end of the first settle window finishing at or after cycle r.
            exp_wr = ((r + 2) / 3) * 3 + 1;
            run_scan(r, idx, dir, -1, -1);
            n_checks++;
            if (r_nwr !== 1 || r_wrcyc !== exp_wr || r_wrsel !== idx || r_wrdir !== dir) begin
                n_fail++;
                $display("FAIL wr_scan%0d: n %0d cyc %0d sel %0d dir %0d expected 1 %0d %0d %0d",
                         k, r_nwr, r_wrcyc, r_wrsel, r_wrdir, exp_wr, idx, dir);
            end
            n_checks++;
            if (r_snap !== 21 || r_nack !== 1 || r_badrd !== 0 || r_miderr !== 0) begin
                n_fail++;
                $display("FAIL wr_scan_timing%0d: snap %0d ack %0d badrd %0d mid %0d expected 21 1 0 0",
                         k, r_snap, r_nack, r_badrd, r_miderr);
            end
            model_commit();
            for (int i = 0; i < 8; i++) begin
                cpu_rd_idx = 3'(i);
                #1;
                n_checks++;
                if (cpu_rd_X !== vis_x[i] || cpu_rd_Y !== vis_y[i] ||
                    cpu_rd_Active !== vis_a[i]) begin
                    n_fail++;
                    $display("FAIL wr_scan_read%0d[%0d]: got %0d %0d %0d expected %0d %0d %0d",
                             k, i, cpu_rd_X, cpu_rd_Y, cpu_rd_Active, vis_x[i], vis_y[i],
                             vis_a[i]);
                end
            end
            cpu_wr_req = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic test_bad_idx();
        logic [2:0] list [3];
        int         w;
        int         a;
        list[0] = 3'd0;
        list[1] = 3'd7;
        list[2] = 3'd6;
        for (int k = 0; k < 3; k++) begin
            cpu_wr_idx = list[k];
            cpu_wr_dir = 2'($urandom);
            cpu_wr_req = 1'b1;
            w = 0;
            a = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                w += int'(ent_write);
                a += int'(cpu_wr_ack);
            end
            n_checks++;
            if (w !== 0 || a !== 1) begin
                n_fail++;
                $display("FAIL bad_idx%0d: writes %0d acks %0d expected 0 1", list[k], w, a);
            end
            cpu_wr_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_overrun();
        int busy;
        fill_random();
        run_scan(-1, 3'd0, 2'd0, 5, -1);
        n_checks++;
        if (r_snap !== 20 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: snap %0d overrun %b expected 20 1", r_snap, overrun);
        end
        model_commit();
        busy = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            busy += int'(scan_busy) + int'(snap_valid);
        end
        n_checks++;
        if (busy !== 0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_single_scan: activity %0d overrun %b expected 0 1", busy, overrun);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got %b expected 0", overrun);
        end
        // Clear and a colliding frame_start in the same cycle: set wins.
        fill_random();
        run_scan(-1, 3'd0, 2'd0, 7, 7);
        n_checks++;
        if (r_snap !== 20 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set_wins: snap %0d overrun %b expected 20 1", r_snap, overrun);
        end
        model_commit();
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_scan();
        logic [9:0] obs;
        int         act;
        fill_random();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        n_checks++;
        if (ent_read !== 1'b1 || scan_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midscan_active: read %b busy %b expected 1 1", ent_read, scan_busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        obs = {ent_select, ent_read, ent_write, ent_sel_dir, cpu_wr_ack, snap_valid, scan_busy,
               overrun};
        n_checks++;
        if (obs !== 10'd0) begin
            n_fail++;
            $display("FAIL midscan_reset_outputs: got %b expected 0", obs);
        end
        for (int i = 0; i < 8; i++) begin
            cpu_rd_idx = 3'(i);
            #1;
            n_checks++;
            if ({cpu_rd_X, cpu_rd_Y, cpu_rd_Active} !== 21'd0) begin
                n_fail++;
                $display("FAIL midscan_reset_read[%0d]: got %h expected 0", i,
                         {cpu_rd_X, cpu_rd_Y, cpu_rd_Active});
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        act = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            act += int'(snap_valid) + int'(scan_busy);
        end
        n_checks++;
        if (act !== 0) begin
            n_fail++;
            $display("FAIL midscan_no_snap: activity %0d expected 0", act);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        frame_start = 1'b0;
        cpu_wr_req  = 1'b0;
        cpu_wr_idx  = '0;
        cpu_wr_dir  = '0;
        cpu_rd_idx  = '0;
        ovr_clr     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tab_x[i] = '0;
            tab_y[i] = '0;
            tab_a[i] = 1'b0;
        end
        test_reset();
        test_scan_basic();
        test_random_scans();
        test_write_idle();
        test_write_during_scan();
        test_bad_idx();
        test_overrun();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached expected completion");
        $fatal(1, "timeout");
    end

endmodule
